i2s_tdm_clock: RTL and testbench
================================

// Module: i2s_tdm_clock
// PURPOSE
//  Parametrised bit/frame clock master for I2S and TDM microphone/codec links.
//  Divides system clock ck to SCK and generates WS plus frame/slot/bit position for capture/shift logic.
//  Adds enable, resync, SCK edge strobes, a frame-start pulse, N-channel TDM, and a pulsed-WS mode.
// PARAMETERS
//  CLK_DIV    12  ck cycles per SCK period; even, >=2 (12MHz/12 = 1MHz SCK)
//  SLOT_BITS  32  SCK periods per channel slot; power of 2, 8..32
//  CHANNELS   2   slots per frame; 1..16, need not be power of 2
//  WS_MODE    0   0 = I2S (WS 50% duty, low for first half of slots); 1 = TDM (WS high for one bit, last bit of frame)
//  Derived: FRAME_BITS=SLOT_BITS*CHANNELS; FW=$clog2(FRAME_BITS); SW=max(1,$clog2(CHANNELS)); BW=$clog2(SLOT_BITS); HALF=CLK_DIV/2
// PORTS
//  ck           in   1   system clock
//  rst_n        in   1   asynchronous reset, active low
//  en           in   1   run enable; low freezes counters
//  sync         in   1   restart frame at position 0 (one-ck pulse)
//  sck          out  1   bit clock, registered
//  ws           out  1   word select / frame sync, registered
//  sck_rise     out  1   one-ck strobe, high in first ck cycle with sck=1
//  sck_fall     out  1   one-ck strobe, high in first ck cycle with sck=0 after a high phase
//  frame_posn   out  FW  bit position in frame, 0..FRAME_BITS-1
//  slot         out  SW  = frame_posn / SLOT_BITS (upper bits)
//  bit_posn     out  BW  = frame_posn % SLOT_BITS (lower bits)
//  frame_start  out  1   one-ck pulse, first ck cycle where frame_posn=0
// BEHAVIOUR
//  Reset: prescale=0, frame_posn=0, sck=0, ws=0, sck_rise=0, sck_fall=0, frame_start=0; slot/bit_posn follow (0).
//  Prescaler 0..CLK_DIV-1: increments when en=1; at CLK_DIV-1 wraps to 0; frame_posn +1 on wrap.
//  frame_posn wraps FRAME_BITS-1 -> 0 explicitly (required for non-power-of-2 CHANNELS).
//  sck <= (prescale >= HALF); sck_rise <= (prescale == HALF); sck_fall <= (prescale == 0 && sck == 1).
//  ws (registered from current frame_posn; lags it by one ck):
//   WS_MODE 0: ws <= (slot >= CHANNELS/2); CHANNELS=1 -> ws stays 0.
//   WS_MODE 1: ws <= (frame_posn == FRAME_BITS-1).
//  frame_start <= 1 in cycle frame_posn wraps to 0, or cycle after sync; else 0.
//  en=0: prescale, frame_posn, ws hold; sck forced 0 next cycle; sck_rise/frame_start=0; sck_fall fires once if sck was 1.
//  en 0->1: resumes from held prescale/frame_posn; no reset of position.
//  sync=1 (any en): next cycle prescale=0, frame_posn=0, sck=0, frame_start=1; sync beats en and beats wrap.
//  rst_n low mid-frame: all outputs to reset values immediately (async); run resumes at posn 0 on release.
//  No combinational paths input->output; every output is a flop (slot/bit_posn are slices of frame_posn).
// STRUCTURE
//  Package i2s_pkg: WS_MODE_I2S=0, WS_MODE_TDM=1 constants; derived-width localparam helpers.
//  Sub-module i2s_prescaler: CLK_DIV counter with en/sync, emits tick (wrap), rise, fall, sck_next.
//  Top holds frame counter, ws/frame_start logic, output registers; parameter checks in elaboration asserts.
// TESTING
//  Defaults, en=1: sck period 12 ck, high 6; ws low posn 0..31 high 32..63; frame_start every 768 ck.
//  CHANNELS=6, SLOT_BITS=16, WS_MODE=1, CLK_DIV=4: posn wraps 95->0, ws high only when posn 95 (lag 1 ck), slot 0..5.
//  sck_rise/sck_fall: exactly one pulse each per SCK period; rise coincides with sck's first high ck.
//  en low at posn 20 for 50 ck: sck 0, posn holds 20; on en high continues 20->21 after remaining prescale.
//  sync at posn 40 (and simultaneous with wrap at 63): next cycle posn 0, prescale 0, frame_start=1 once.
//  rst_n asserted mid-frame asynchronously: outputs 0 without ck edge; restart from posn 0.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared constants and width helpers for the I2S/TDM bit/frame clock master.
package i2s_pkg;

  localparam int WS_MODE_I2S = 0;
  localparam int WS_MODE_TDM = 1;

  // Width of the frame position counter
  function automatic int frame_width(input int slot_bits, input int channels);
    return $clog2(slot_bits * channels);
  endfunction

  // Width of the slot index; never narrower than one bit so mono links still have a port
  function automatic int slot_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  // Width of the bit-within-slot index
  function automatic int bit_width(input int slot_bits);
    return $clog2(slot_bits);
  endfunction

endpackage

// File: rtl/i2s_prescaler.sv
// Divides ck into SCK periods. Holds the prescale counter and produces the
// next-cycle values of sck and its edge strobes; the top registers them.
module i2s_prescaler #(
  parameter int CLK_DIV = 12
) (
  input  logic ck,
  input  logic rst_n,
  input  logic en,
  input  logic sync,
  input  logic sck,
  output logic tick,
  output logic sck_next,
  output logic rise_next,
  output logic fall_next
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PRE_HALF = PW'(CLK_DIV / 2);

  logic [PW-1:0] prescale;

  // Prescale counter: sync restarts the SCK period, en gates counting
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      prescale <= '0;
    end else if (sync) begin
      prescale <= '0;
    end else if (en) begin
      if (prescale == PRE_LAST) prescale <= '0;
      else                      prescale <= prescale + 1'b1;
    end
  end

  // Wrap strobe advances the frame position; suppressed by sync so sync wins
  assign tick = en & ~sync & (prescale == PRE_LAST);

  // Next sck and strobes; when stopped or resyncing sck drops, and a fall
  // is reported once if it was high
  always_comb begin
    sck_next  = 1'b0;
    rise_next = 1'b0;
    fall_next = sck;
    if (!sync && en) begin
      sck_next  = (prescale >= PRE_HALF);
      rise_next = (prescale == PRE_HALF);
      fall_next = (prescale == '0) & sck;
    end
  end

endmodule

// File: rtl/i2s_tdm_clock.sv
// Bit/frame clock master for I2S and TDM links: SCK, WS and frame/slot/bit
// position for the capture and shift logic. All outputs are flops.
module i2s_tdm_clock
  import i2s_pkg::*;
#(
  parameter  int CLK_DIV    = 12,
  parameter  int SLOT_BITS  = 32,
  parameter  int CHANNELS   = 2,
  parameter  int WS_MODE    = WS_MODE_I2S,
  localparam int FRAME_BITS = SLOT_BITS * CHANNELS,
  localparam int FW         = frame_width(SLOT_BITS, CHANNELS),
  localparam int SW         = slot_width(CHANNELS),
  localparam int BW         = bit_width(SLOT_BITS)
) (
  input  logic          ck,
  input  logic          rst_n,
  input  logic          en,
  input  logic          sync,
  output logic          sck,
  output logic          ws,
  output logic          sck_rise,
  output logic          sck_fall,
  output logic [FW-1:0] frame_posn,
  output logic [SW-1:0] slot,
  output logic [BW-1:0] bit_posn,
  output logic          frame_start
);

  if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_div
    $error("CLK_DIV must be even and at least 2");
  end
  if (SLOT_BITS < 8 || SLOT_BITS > 32 || (SLOT_BITS & (SLOT_BITS - 1)) != 0) begin : g_bad_slot
    $error("SLOT_BITS must be a power of two in 8..32");
  end
  if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_ch
    $error("CHANNELS must be in 1..16");
  end
  if (WS_MODE != WS_MODE_I2S && WS_MODE != WS_MODE_TDM) begin : g_bad_mode
    $error("WS_MODE must be 0 (I2S) or 1 (TDM)");
  end

  localparam logic [FW-1:0] POSN_LAST = FW'(FRAME_BITS - 1);

  logic tick;
  logic sck_next;
  logic rise_next;
  logic fall_next;
  logic ws_next;
  logic posn_last;

  i2s_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .ck        (ck),
    .rst_n     (rst_n),
    .en        (en),
    .sync      (sync),
    .sck       (sck),
    .tick      (tick),
    .sck_next  (sck_next),
    .rise_next (rise_next),
    .fall_next (fall_next)
  );

  assign posn_last = (frame_posn == POSN_LAST);

  // Frame position: explicit wrap so non-power-of-two channel counts work
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      frame_posn <= '0;
    end else if (sync) begin
      frame_posn <= '0;
    end else if (tick) begin
      if (posn_last) frame_posn <= '0;
      else           frame_posn <= frame_posn + 1'b1;
    end
  end

  // Slot and bit indices are plain slices because SLOT_BITS is a power of two
  if (CHANNELS == 1) begin : g_mono
    assign slot = '0;
  end else begin : g_multi
    assign slot = frame_posn[FW-1:BW];
  end
  assign bit_posn = frame_posn[BW-1:0];

  // Word select source: second half of slots for I2S, last frame bit for TDM
  if (WS_MODE == WS_MODE_TDM) begin : g_ws_tdm
    assign ws_next = posn_last;
  end else if (CHANNELS == 1) begin : g_ws_mono
    assign ws_next = 1'b0;
  end else begin : g_ws_i2s
    assign ws_next = (slot >= SW'(CHANNELS / 2));
  end

  // Output registers; ws lags frame_posn by one ck and freezes while disabled
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      sck         <= 1'b0;
      sck_rise    <= 1'b0;
      sck_fall    <= 1'b0;
      ws          <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      sck         <= sck_next;
      sck_rise    <= rise_next;
      sck_fall    <= fall_next;
      frame_start <= sync | (tick & posn_last);
      if (en) ws <= ws_next;
    end
  end

endmodule

// File: tb/tb_i2s_tdm_clock.sv
// Randomised bench for i2s_tdm_clock: two configurations (default I2S and a
// 6-channel TDM) run side by side against a timeline-based reference model.
module tb_i2s_tdm_clock;

  logic ck;
  logic rst_n;
  logic en;
  logic sync;

  // Default configuration: 12 div, 32 bits, 2 ch, I2S
  logic       sck0, ws0, rise0, fall0, fs0;
  logic [5:0] posn0;
  logic [0:0] slot0;
  logic [4:0] bit0;

  // TDM configuration: 4 div, 16 bits, 6 ch, pulsed WS
  logic       sck1, ws1, rise1, fall1, fs1;
  logic [6:0] posn1;
  logic [2:0] slot1;
  logic [3:0] bit1;

  int n_checks;
  int n_pass;

  i2s_tdm_clock u_dut0 (
    .ck (ck), .rst_n (rst_n), .en (en), .sync (sync),
    .sck (sck0), .ws (ws0), .sck_rise (rise0), .sck_fall (fall0),
    .frame_posn (posn0), .slot (slot0), .bit_posn (bit0), .frame_start (fs0)
  );

  i2s_tdm_clock #(
    .CLK_DIV (4), .SLOT_BITS (16), .CHANNELS (6), .WS_MODE (1)
  ) u_dut1 (
    .ck (ck), .rst_n (rst_n), .en (en), .sync (sync),
    .sck (sck1), .ws (ws1), .sck_rise (rise1), .sck_fall (fall1),
    .frame_posn (posn1), .slot (slot1), .bit_posn (bit1), .frame_start (fs1)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  // Model state: position on a single ck-resolution timeline within the frame
  typedef struct {
    int tot;
    bit sck;
    bit ws;
    bit rise;
    bit fall;
    bit fs;
  } mstate_t;

  mstate_t m0, m1;

  localparam int D0 = 12, S0 = 32, C0 = 2, W0 = 0;
  localparam int D1 = 4,  S1 = 16, C1 = 6, W1 = 1;

  function automatic bit ws_rule(input int posn, input int sb, input int ch, input int mode);
    if (mode == 1) return posn == sb * ch - 1;
    return (ch > 1) && (posn / sb >= ch / 2);
  endfunction

  function automatic mstate_t step(input mstate_t s, input int div, input int sb,
                                   input int ch, input int mode, input bit e, input bit sy);
    mstate_t n;
    int period, pre, posn;
    n      = s;
    period = div * sb * ch;
    pre    = s.tot % div;
    posn   = s.tot / div;
    if (e) n.ws = ws_rule(posn, sb, ch, mode);
    if (sy) begin
      n.tot  = 0;
      n.sck  = 1'b0;
      n.rise = 1'b0;
      n.fall = s.sck;
      n.fs   = 1'b1;
    end else if (e) begin
      n.tot  = (s.tot + 1) % period;
      n.sck  = (pre >= div / 2);
      n.rise = (pre == div / 2);
      n.fall = (pre == 0) && s.sck;
      n.fs   = (n.tot == 0);
    end else begin
      n.sck  = 1'b0;
      n.rise = 1'b0;
      n.fall = s.sck;
      n.fs   = 1'b0;
    end
    return n;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic compare_all();
    int p0, p1;
    p0 = m0.tot / D0;
    p1 = m1.tot / D1;
    check("d0_posn", int'(posn0), p0);
    check("d0_slot", int'(slot0), p0 / S0);
    check("d0_bit",  int'(bit0),  p0 % S0);
    check("d0_sck",  int'(sck0),  int'(m0.sck));
    check("d0_ws",   int'(ws0),   int'(m0.ws));
    check("d0_rise", int'(rise0), int'(m0.rise));
    check("d0_fall", int'(fall0), int'(m0.fall));
    check("d0_fs",   int'(fs0),   int'(m0.fs));
    check("d1_posn", int'(posn1), p1);
    check("d1_slot", int'(slot1), p1 / S1);
    check("d1_bit",  int'(bit1),  p1 % S1);
    check("d1_sck",  int'(sck1),  int'(m1.sck));
    check("d1_ws",   int'(ws1),   int'(m1.ws));
    check("d1_rise", int'(rise1), int'(m1.rise));
    check("d1_fall", int'(fall1), int'(m1.fall));
    check("d1_fs",   int'(fs1),   int'(m1.fs));
  endtask

  // One ck: model follows the inputs seen at the edge, then outputs are compared
  task automatic cycle();
    @(posedge ck);
    if (rst_n) begin
      m0 = step(m0, D0, S0, C0, W0, en, sync);
      m1 = step(m1, D1, S1, C1, W1, en, sync);
    end
    #1;
    compare_all();
  endtask

  task automatic model_reset();
    m0 = '{default: 0};
    m1 = '{default: 0};
  endtask

  initial begin
    int budget;
    int fs_count;
    n_checks = 0;
    n_pass   = 0;
    rst_n = 1'b1;
    en    = 1'b0;
    sync  = 1'b0;
    model_reset();
    #2 rst_n = 1'b0;
    #1 compare_all();
    repeat (3) cycle();
    rst_n = 1'b1;
    en    = 1'b1;

    // Free run across two default frames
    fs_count = 0;
    repeat (1600) begin
      cycle();
      if (fs0) fs_count++;
    end
    check("d0_frames_in_1600", fs_count, 2);

    // Stop at position 20 for 50 ck and resume
    budget = 0;
    while (m0.tot / D0 != 20 && budget < 2000) begin
      cycle();
      budget++;
    end
    check("wait_posn20_timeout", int'(budget < 2000), 1);
    en = 1'b0;
    repeat (50) cycle();
    check("hold_posn20", int'(posn0), 20);
    check("hold_sck0", int'(sck0), 0);
    en = 1'b1;
    repeat (3 * D0) cycle();

    // Sync mid-frame at position 40
    budget = 0;
    while (m0.tot / D0 != 40 && budget < 2000) begin
      cycle();
      budget++;
    end
    check("wait_posn40_timeout", int'(budget < 2000), 1);
    sync = 1'b1;
    cycle();
    sync = 1'b0;
    check("sync40_fs", int'(fs0), 1);
    check("sync40_posn", int'(posn0), 0);
    cycle();
    check("sync40_fs_once", int'(fs0), 0);

    // Sync in the same cycle the frame would wrap
    budget = 0;
    while (m0.tot != D0 * S0 * C0 - 1 && budget < 2000) begin
      cycle();
      budget++;
    end
    check("wait_wrap_timeout", int'(budget < 2000), 1);
    sync = 1'b1;
    cycle();
    sync = 1'b0;
    check("syncwrap_fs", int'(fs0), 1);
    check("syncwrap_posn", int'(posn0), 0);
    cycle();
    check("syncwrap_fs_once", int'(fs0), 0);

    // Random en / sync traffic
    repeat (3000) begin
      en   = ($urandom_range(0, 9) != 0);
      sync = ($urandom_range(0, 149) == 0);
      cycle();
    end
    en   = 1'b1;
    sync = 1'b0;
    repeat (200) cycle();

    // Asynchronous reset mid-frame, away from any ck edge
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    repeat (2) cycle();
    rst_n = 1'b1;
    repeat (900) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
